// File: rtl/mat4_mac_sequencer_if.sv
// Load/result handshake bundle for mat4_mac_sequencer: operand stream in, C stream out,
// plus job control (start/busy/done).
interface mat4_mac_sequencer_if #(
   parameter int Width    = 8,
   parameter int AccWidth = 2 * Width + 2
);
   logic                       start;
   logic                       in_valid;
   logic signed [Width-1:0]    in_data;
   logic                       in_ready;
   logic                       out_valid;
   logic signed [AccWidth-1:0] out_data;
   logic                       out_ready;
   logic                       busy;
   logic                       done;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy, done
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy, done
   );
endinterface

// File: rtl/mat4_mac_sequencer.sv
// 4x4 signed matrix multiply sequencer: loads A then B (32 elements), runs one shared MAC
// over all 64 products and streams C row-major. Optional macro MATMUL_SAT_EN clamps out_data.
module mat4_mac_sequencer #(
   parameter int Width    = 8,
   parameter int AccWidth = 2 * Width + 2
) (
   input logic                 CLK,
   input logic                 reset,
   mat4_mac_sequencer_if.slave seq_if
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_OUT     = 2'd3;

   localparam logic signed [AccWidth-1:0] SAT_MAX = AccWidth'(2 ** (Width - 1) - 1);
   localparam logic signed [AccWidth-1:0] SAT_MIN = ~SAT_MAX;

`ifdef MATMUL_SAT_EN
   function automatic logic signed [AccWidth-1:0] out_fmt(input logic signed [AccWidth-1:0] v);
      if (v > SAT_MAX) return SAT_MAX;
      else if (v < SAT_MIN) return SAT_MIN;
      else return v;
   endfunction
`else
   function automatic logic signed [AccWidth-1:0] out_fmt(input logic signed [AccWidth-1:0] v);
      return v;
   endfunction
`endif

   logic [1:0]                 state_q, state_d;
   logic [4:0]                 cnt_q, cnt_d;
   logic [1:0]                 i_q, i_d, j_q, j_d, k_q, k_d;
   logic                       done_q, done_d;
   logic signed [AccWidth-1:0] acc_q, acc_d;
   logic signed [AccWidth-1:0] out_q, out_d;
   logic signed [Width-1:0]    a_q [16];
   logic signed [Width-1:0]    b_q [16];
   logic                       ld_en;

   logic signed [Width-1:0]    a_sel, b_sel;
   logic signed [2*Width-1:0]  prod;
   logic signed [AccWidth-1:0] prod_ext, acc_base, mac_sum;

   // MAC operand select and sum (combinational, registered into acc_q / out_q)
   assign a_sel    = a_q[{i_q, k_q}];
   assign b_sel    = b_q[{k_q, j_q}];
   assign prod     = a_sel * b_sel;
   assign prod_ext = {{(AccWidth - 2 * Width){prod[2*Width-1]}}, prod};
   assign acc_base = (k_q == 2'd0) ? '0 : acc_q;
   assign mac_sum  = acc_base + prod_ext;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      done_d  = 1'b0;
      acc_d   = acc_q;
      out_d   = out_q;
      ld_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (seq_if.start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (seq_if.in_valid) begin
               ld_en = 1'b1;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d = S_COMPUTE;
                  i_d     = '0;
                  j_d     = '0;
                  k_d     = '0;
               end
            end
         end
         S_COMPUTE: begin
            acc_d = mac_sum;
            k_d   = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = S_OUT;
               out_d   = out_fmt(mac_sum);
            end
         end
         S_OUT: begin
            if (seq_if.out_ready) begin
               j_d = j_q + 2'd1;
               if (j_q == 2'd3) i_d = i_q + 2'd1;
               if (i_q == 2'd3 && j_q == 2'd3) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_COMPUTE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         done_q  <= done_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   // Operand banks: bit 4 of the load counter selects B, low bits give the row-major index
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int n = 0; n < 16; n++) begin
            a_q[n] <= '0;
            b_q[n] <= '0;
         end
      end else if (ld_en) begin
         if (cnt_q[4]) b_q[cnt_q[3:0]] <= seq_if.in_data;
         else          a_q[cnt_q[3:0]] <= seq_if.in_data;
      end
   end

   assign seq_if.in_ready  = (state_q == S_LOAD);
   assign seq_if.out_valid = (state_q == S_OUT);
   assign seq_if.out_data  = out_q;
   assign seq_if.busy      = (state_q != S_IDLE);
   assign seq_if.done      = done_q;

   a_out_hold: assert property (@(posedge CLK) disable iff (reset)
      (seq_if.out_valid && !seq_if.out_ready) |=> (seq_if.out_valid && $stable(seq_if.out_data)));
   a_ready_excl: assert property (@(posedge CLK) !(seq_if.in_ready && seq_if.out_valid));
   a_done_idle: assert property (@(posedge CLK) seq_if.done |-> !seq_if.busy);

endmodule

// File: tb/tb_mat4_mac_sequencer.sv
// Scoreboard bench for mat4_mac_sequencer: expected C elements are queued per job from a
// reference product and popped on each output handshake.
module tb_mat4_mac_sequencer;
   localparam int Width    = 8;
   localparam int AccWidth = 18;

   logic clk;
   logic reset;

   mat4_mac_sequencer_if #(.Width(Width), .AccWidth(AccWidth)) seq_if ();

   mat4_mac_sequencer #(.Width(Width), .AccWidth(AccWidth)) dut (
      .CLK    (clk),
      .reset  (reset),
      .seq_if (seq_if)
   );

   int     total = 0;
   int     bad   = 0;
   longint exp_q [$];
   int     out_cnt  = 0;
   int     done_cnt = 0;
   int     ea [16];
   int     eb [16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint ref_fmt(input longint v);
`ifdef MATMUL_SAT_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
`endif
      return v;
   endfunction

   task automatic push_expected();
      longint s;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += longint'(ea[4*i+k]) * longint'(eb[4*k+j]);
            exp_q.push_back(ref_fmt(s));
         end
   endtask

   always @(negedge clk) begin
      if (!reset && seq_if.out_valid && seq_if.out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
         else chk($sformatf("c_elem%0d", out_cnt % 16), seq_if.out_data, exp_q.pop_front());
         out_cnt++;
      end
      if (seq_if.done) done_cnt++;
   end

   task automatic run_job(input bit gaps, input bit disturb, input int stall_at, input int reset_at);
      int base_out, base_done, idx;
      bit hs, finished, tog, extra_done, stalled;
      push_expected();
      base_out  = out_cnt;
      base_done = done_cnt;
      @(posedge clk); #1;
      seq_if.start = 1'b1;
      @(posedge clk); #1;
      seq_if.start = 1'b0;
      idx = 0;
      tog = 1'b0;
      for (int cyc = 0; cyc < 200 && idx < 32; cyc++) begin
         tog = ~tog;
         seq_if.in_valid = gaps ? tog : 1'b1;
         seq_if.in_data  = 8'(idx < 16 ? ea[idx] : eb[idx-16]);
         hs = seq_if.in_valid && seq_if.in_ready;
         @(posedge clk); #1;
         if (hs) idx++;
      end
      seq_if.in_valid = 1'b0;
      chk("load_count", idx, 32);

      finished   = 1'b0;
      extra_done = 1'b0;
      stalled    = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         if (reset_at >= 0 && out_cnt - base_out == reset_at && seq_if.busy && !seq_if.out_valid) begin
            reset = 1'b1;
            @(posedge clk); #1;
            chk("rst_in_ready", seq_if.in_ready, 0);
            chk("rst_out_valid", seq_if.out_valid, 0);
            chk("rst_busy", seq_if.busy, 0);
            chk("rst_done", seq_if.done, 0);
            chk("rst_out_data", seq_if.out_data, 0);
            reset = 1'b0;
            exp_q.delete();
            finished = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            chk("rst_no_done", done_cnt - base_done, 0);
            chk("rst_stays_idle", seq_if.busy, 0);
         end else begin
            if (stall_at >= 0 && !stalled && out_cnt - base_out == stall_at && seq_if.out_valid) begin
               stalled = 1'b1;
               seq_if.out_ready = 1'b0;
               repeat (10) begin
                  @(posedge clk); #1;
                  chk("stall_valid", seq_if.out_valid, 1);
                  chk("stall_data", seq_if.out_data, exp_q.size() > 0 ? exp_q[0] : 0);
               end
               seq_if.out_ready = 1'b1;
            end
            if (disturb) begin
               seq_if.start = (!extra_done && out_cnt - base_out == 3 && seq_if.busy && !seq_if.out_valid);
               if (seq_if.start) extra_done = 1'b1;
               seq_if.in_valid = 1'($urandom_range(0, 1));
               seq_if.in_data  = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            seq_if.start = 1'b0;
            if (seq_if.done) begin
               finished = 1'b1;
               chk("busy_at_done", seq_if.busy, 0);
               chk("ready_at_done", seq_if.in_ready, 0);
            end
         end
      end
      seq_if.in_valid = 1'b0;
      seq_if.start    = 1'b0;
      if (reset_at < 0) begin
         chk("job_done", finished, 1);
         if (disturb) chk("extra_start_issued", extra_done, 1);
         if (stall_at >= 0) chk("stall_issued", stalled, 1);
         @(posedge clk); #1;
         chk("done_one_cycle", seq_if.done, 0);
         @(negedge clk);
         chk("done_pulses", done_cnt - base_done, 1);
         chk("sb_empty", exp_q.size(), 0);
         chk("elements_out", out_cnt - base_out, 16);
         exp_q.delete();
      end
   endtask

   task automatic fill_random();
      for (int n = 0; n < 16; n++) begin
         ea[n] = int'($urandom_range(0, 255)) - 128;
         eb[n] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   initial begin
      reset            = 1'b1;
      seq_if.start     = 1'b0;
      seq_if.in_valid  = 1'b0;
      seq_if.in_data   = '0;
      seq_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", seq_if.in_ready, 0);
      chk("reset_out_valid", seq_if.out_valid, 0);
      chk("reset_busy", seq_if.busy, 0);
      chk("reset_done", seq_if.done, 0);
      chk("reset_out_data", seq_if.out_data, 0);
      reset = 1'b0;

      seq_if.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_in_ready", seq_if.in_ready, 0);
      chk("idle_busy", seq_if.busy, 0);
      seq_if.in_valid = 1'b0;

      for (int n = 0; n < 16; n++) begin
         ea[n] = (n / 4 == n % 4) ? 1 : 0;
         eb[n] = n + 1;
      end
      run_job(1'b0, 1'b0, -1, -1);

      for (int n = 0; n < 16; n++) begin
         ea[n] = -128;
         eb[n] = -128;
      end
      run_job(1'b0, 1'b0, -1, -1);

      for (int n = 0; n < 16; n++) begin
         ea[n] = 127;
         eb[n] = -128;
      end
      run_job(1'b0, 1'b0, -1, -1);

      fill_random();
      run_job(1'b0, 1'b0, 6, -1);
      run_job(1'b1, 1'b1, -1, -1);

      fill_random();
      run_job(1'b0, 1'b0, -1, 9);

      fill_random();
      run_job(1'b0, 1'b0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
